// File: rtl/knn_pkg.sv
// Shared constants, FSM encoding and width helpers for the KNN top-K selector.
// Imported by the interface, the vote counter and the top level.
package knn_pkg;

  localparam int unsigned DefDistW  = 64;
  localparam int unsigned DefLabelW = 8;

  typedef enum logic [1:0] {
    StFill,
    StVote,
    StDone
  } state_e;

  // Width able to hold any count 0..k.
  function automatic int unsigned cnt_w(input int unsigned k);
    return $clog2(k + 1);
  endfunction

  // Width of an index into a k-entry list; never below one bit.
  function automatic int unsigned idx_w(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/knn_topk_if.sv
// Sample input and result output handshakes of knn_topk.
// The master drives samples and consumes results; the slave is the selector.
interface knn_topk_if
  import knn_pkg::*;
#(
  parameter int unsigned DIST_W  = DefDistW,
  parameter int unsigned LABEL_W = DefLabelW,
  parameter int unsigned K       = 4
) ();

  localparam int unsigned CntW = cnt_w(K);

  logic               in_valid;
  logic               in_ready;
  logic [DIST_W-1:0]  in_dist;
  logic [LABEL_W-1:0] in_label;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [LABEL_W-1:0] out_label;
  logic [CntW-1:0]    out_votes;
  logic [DIST_W-1:0]  out_min_dist;
  logic [CntW-1:0]    out_n;

  modport master (
    output in_valid, in_dist, in_label, in_last, out_ready,
    input  in_ready, out_valid, out_label, out_votes, out_min_dist, out_n
  );

  modport slave (
    input  in_valid, in_dist, in_label, in_last, out_ready,
    output in_ready, out_valid, out_label, out_votes, out_min_dist, out_n
  );

endinterface

// File: rtl/knn_vote.sv
// Counts the valid list entries whose label matches the label at index sel_i.
// Purely combinational; evaluated once per VOTE cycle.
module knn_vote
  import knn_pkg::*;
#(
  parameter int unsigned LABEL_W = DefLabelW,
  parameter int unsigned K       = 4
) (
  input  logic [K-1:0][LABEL_W-1:0] labels_i,
  input  logic [K-1:0]              valids_i,
  input  logic [idx_w(K)-1:0]       sel_i,
  output logic [cnt_w(K)-1:0]       count_o
);

  localparam int unsigned CntW = cnt_w(K);

  logic [LABEL_W-1:0] sel_label;

  always_comb begin
    sel_label = labels_i[sel_i];
    count_o   = '0;
    for (int k = 0; k < K; k++) begin
      if (valids_i[k] && (labels_i[k] == sel_label)) begin
        count_o = count_o + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/knn_topk.sv
// Streaming K-nearest selector: sorted insertion of (distance, label) samples,
// then a K-cycle majority vote presented on a registered valid/ready output.
module knn_topk
  import knn_pkg::*;
#(
  parameter int unsigned DIST_W  = DefDistW,
  parameter int unsigned LABEL_W = DefLabelW,
  parameter int unsigned K       = 4
) (
  input logic       clk,
  input logic       rst_n,
  input logic       clear,
  knn_topk_if.slave bus_io
);

  localparam int unsigned CntW = cnt_w(K);
  localparam int unsigned IdxW = idx_w(K);

  state_e                    state_q, state_d;
  logic [K-1:0]              vld_q, vld_d;
  logic [K-1:0][DIST_W-1:0]  dist_q, dist_d;
  logic [K-1:0][LABEL_W-1:0] lbl_q, lbl_d;
  logic [CntW-1:0]           n_q, n_d;
  logic [IdxW-1:0]           j_q, j_d;
  logic [LABEL_W-1:0]        best_lbl_q, best_lbl_d;
  logic [CntW-1:0]           best_cnt_q, best_cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic [LABEL_W-1:0]        out_label_q, out_label_d;
  logic [CntW-1:0]           out_votes_q, out_votes_d;
  logic [DIST_W-1:0]         out_min_q, out_min_d;

  logic [K-1:0]    lt;
  logic [CntW-1:0] vote_cnt;
  logic            accept;

  knn_vote #(
    .LABEL_W (LABEL_W),
    .K       (K)
  ) u_vote (
    .labels_i (lbl_q),
    .valids_i (vld_q),
    .sel_i    (j_q),
    .count_o  (vote_cnt)
  );

  always_comb begin
    accept = (state_q == StFill) && bus_io.in_valid;
    // The list is sorted with valid entries first, so lt is a thermometer code.
    for (int k = 0; k < K; k++) begin
      lt[k] = !vld_q[k] || (bus_io.in_dist < dist_q[k]);
    end

    state_d     = state_q;
    vld_d       = vld_q;
    dist_d      = dist_q;
    lbl_d       = lbl_q;
    n_d         = n_q;
    j_d         = j_q;
    best_lbl_d  = best_lbl_q;
    best_cnt_d  = best_cnt_q;
    out_valid_d = out_valid_q;
    out_label_d = out_label_q;
    out_votes_d = out_votes_q;
    out_min_d   = out_min_q;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (lt[0]) begin
            vld_d[0]  = 1'b1;
            dist_d[0] = bus_io.in_dist;
            lbl_d[0]  = bus_io.in_label;
          end
          for (int k = 1; k < K; k++) begin
            if (lt[k] && lt[k-1]) begin
              vld_d[k]  = vld_q[k-1];
              dist_d[k] = dist_q[k-1];
              lbl_d[k]  = lbl_q[k-1];
            end else if (lt[k]) begin
              vld_d[k]  = 1'b1;
              dist_d[k] = bus_io.in_dist;
              lbl_d[k]  = bus_io.in_label;
            end
          end
          if (n_q != CntW'(K)) n_d = n_q + CntW'(1);
          if (bus_io.in_last) begin
            state_d    = StVote;
            j_d        = '0;
            best_lbl_d = '0;
            best_cnt_d = '0;
          end
        end
      end
      StVote: begin
        if (vld_q[j_q] && (vote_cnt > best_cnt_q)) begin
          best_lbl_d = lbl_q[j_q];
          best_cnt_d = vote_cnt;
        end
        if (j_q == IdxW'(K - 1)) state_d = StDone;
        else                     j_d     = j_q + IdxW'(1);
      end
      StDone: begin
        // First DONE cycle registers the result; the handshake is honoured afterwards.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_label_d = best_lbl_q;
          out_votes_d = best_cnt_q;
          out_min_d   = dist_q[0];
        end else if (bus_io.out_ready) begin
          out_valid_d = 1'b0;
          vld_d       = '0;
          n_d         = '0;
          best_lbl_d  = '0;
          best_cnt_d  = '0;
          state_d     = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    if (clear) begin
      state_d     = StFill;
      vld_d       = '0;
      n_d         = '0;
      j_d         = '0;
      best_lbl_d  = '0;
      best_cnt_d  = '0;
      out_valid_d = 1'b0;
      out_label_d = '0;
      out_votes_d = '0;
      out_min_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      vld_q       <= '0;
      dist_q      <= '0;
      lbl_q       <= '0;
      n_q         <= '0;
      j_q         <= '0;
      best_lbl_q  <= '0;
      best_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_label_q <= '0;
      out_votes_q <= '0;
      out_min_q   <= '0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      dist_q      <= dist_d;
      lbl_q       <= lbl_d;
      n_q         <= n_d;
      j_q         <= j_d;
      best_lbl_q  <= best_lbl_d;
      best_cnt_q  <= best_cnt_d;
      out_valid_q <= out_valid_d;
      out_label_q <= out_label_d;
      out_votes_q <= out_votes_d;
      out_min_q   <= out_min_d;
    end
  end

  assign bus_io.in_ready     = (state_q == StFill);
  assign bus_io.out_valid    = out_valid_q;
  assign bus_io.out_label    = out_label_q;
  assign bus_io.out_votes    = out_votes_q;
  assign bus_io.out_min_dist = out_min_q;
  assign bus_io.out_n        = n_q;

endmodule
